// File: rtl/xgmii_tx_encap.sv
// AXI-Stream to XGMII transmit framer: preamble/SFD, terminate, idle, error codes and minimum IFG.
// Optional statistics counters are enabled with `define XGMII_TX_STATS_EN.
module xgmii_tx_encap #(
   parameter int unsigned C_MIN_IFG_WORDS = 1
) (
   input  logic        clk156,
   input  logic        tx_axis_aresetn,
   input  logic        tx_enable,
   input  logic [63:0] tx_axis_tdata,
   input  logic [7:0]  tx_axis_tkeep,
   input  logic        tx_axis_tvalid,
   input  logic        tx_axis_tlast,
   output logic        tx_axis_tready,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc,
   output logic        tx_underrun
`ifdef XGMII_TX_STATS_EN
   ,
   output logic [31:0] stat_frames,
   output logic [15:0] stat_underruns
`endif
);

   localparam int          NUM_LANES = 8;
   localparam logic [63:0] IDLE_W    = {8{8'h07}};
   localparam logic [63:0] PRE_W     = 64'hD5555555555555FB;
   localparam logic [63:0] ERR_W     = {8{8'hFE}};
   localparam logic [63:0] TERM_W    = 64'h07070707070707FD;
   localparam logic [3:0]  IFG_LOAD  = 4'(C_MIN_IFG_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_DATA, S_TERM, S_ERR, S_DISCARD, S_IFG
   } state_t;

   state_t      state_q;
   logic [63:0] txd_q;
   logic [7:0]  txc_q;
   logic        underrun_q;
   logic        last_seen_q;
   logic [3:0]  ifg_cnt_q;
`ifdef XGMII_TX_STATS_EN
   logic [31:0] stat_frames_q;
   logic [15:0] stat_underruns_q;
`endif

   logic [3:0]  keep_n;
   logic [63:0] lastw_txd;
   logic [7:0]  lastw_txc;

   // Valid byte count = run of ones from lane 0; anything above the first zero is ignored.
   always_comb begin
      keep_n = 4'd8;
      for (int i = NUM_LANES - 1; i >= 0; i--)
         if (!tx_axis_tkeep[i]) keep_n = 4'(i);
   end

   // Last-beat word: data below keep_n, FD at keep_n, idle above. keep_n=8 yields the plain data word.
   always_comb begin
      lastw_txd = IDLE_W;
      lastw_txc = 8'hFF;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (4'(i) < keep_n) begin
            lastw_txd[8*i +: 8] = tx_axis_tdata[8*i +: 8];
            lastw_txc[i]        = 1'b0;
         end else if (4'(i) == keep_n) begin
            lastw_txd[8*i +: 8] = 8'hFD;
         end
      end
   end

   // If the errored frame had already delivered tlast there is nothing left to drop.
   assign tx_axis_tready = (state_q == S_PRE) || (state_q == S_DATA) ||
                           (state_q == S_DISCARD && !last_seen_q);

   always_ff @(posedge clk156 or negedge tx_axis_aresetn) begin
      if (!tx_axis_aresetn) begin
         state_q     <= S_IDLE;
         txd_q       <= IDLE_W;
         txc_q       <= 8'hFF;
         underrun_q  <= 1'b0;
         last_seen_q <= 1'b0;
         ifg_cnt_q   <= 4'd0;
`ifdef XGMII_TX_STATS_EN
         stat_frames_q    <= 32'd0;
         stat_underruns_q <= 16'd0;
`endif
      end else begin
         txd_q      <= IDLE_W;
         txc_q      <= 8'hFF;
         underrun_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tx_axis_tvalid && tx_enable) begin
                  state_q     <= S_PRE;
                  txd_q       <= PRE_W;
                  txc_q       <= 8'h01;
                  last_seen_q <= 1'b0;
               end
            end
            S_PRE, S_DATA: begin
               if (tx_axis_tvalid) begin
                  last_seen_q <= tx_axis_tlast;
                  if (tx_axis_tlast) begin
                     txd_q     <= lastw_txd;
                     txc_q     <= lastw_txc;
                     state_q   <= (keep_n == 4'd8) ? S_TERM : S_IFG;
                     ifg_cnt_q <= IFG_LOAD;
`ifdef XGMII_TX_STATS_EN
                     stat_frames_q <= stat_frames_q + 32'd1;
`endif
                  end else begin
                     txd_q   <= tx_axis_tdata;
                     txc_q   <= 8'h00;
                     state_q <= S_DATA;
                  end
               end else begin
                  txd_q      <= ERR_W;
                  underrun_q <= 1'b1;
                  state_q    <= S_ERR;
`ifdef XGMII_TX_STATS_EN
                  stat_underruns_q <= stat_underruns_q + 16'd1;
`endif
               end
            end
            S_TERM: begin
               txd_q     <= TERM_W;
               state_q   <= S_IFG;
               ifg_cnt_q <= IFG_LOAD;
            end
            S_ERR: begin
               txd_q   <= TERM_W;
               state_q <= S_DISCARD;
            end
            S_DISCARD: begin
               if (last_seen_q || (tx_axis_tvalid && tx_axis_tlast)) begin
                  state_q   <= S_IFG;
                  ifg_cnt_q <= IFG_LOAD;
               end
            end
            S_IFG: begin
               if (ifg_cnt_q == 4'd0) state_q <= S_IDLE;
               else                   ifg_cnt_q <= ifg_cnt_q - 4'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign xgmii_txd   = txd_q;
   assign xgmii_txc   = txc_q;
   assign tx_underrun = underrun_q;
`ifdef XGMII_TX_STATS_EN
   assign stat_frames    = stat_frames_q;
   assign stat_underruns = stat_underruns_q;
`endif

endmodule

// File: tb/tb_xgmii_tx_encap.sv
// Directed bench for xgmii_tx_encap: output words are logged each cycle and compared with hand-built sequences.
module tb_xgmii_tx_encap;

   localparam int          IFG    = 1;
   localparam logic [63:0] IDLE_W = 64'h0707070707070707;
   localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
   localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] TERM_W = 64'h07070707070707FD;

   logic        clk156 = 1'b0;
   logic        aresetn = 1'b1;
   logic        tx_enable = 1'b1;
   logic [63:0] tdata = '0;
   logic [7:0]  tkeep = 8'hFF;
   logic        tvalid = 1'b1;
   logic        tlast = 1'b0;
   logic        tready;
   logic [63:0] txd;
   logic [7:0]  txc;
   logic        und;
`ifdef XGMII_TX_STATS_EN
   logic [31:0] sf;
   logic [15:0] su;
`endif

   int n_chk = 0;
   int n_fail = 0;

   bit          cap_en = 1'b0;
   logic [63:0] q_txd[$];
   logic [7:0]  q_txc[$];
   logic        q_und[$];

   xgmii_tx_encap #(.C_MIN_IFG_WORDS(IFG)) dut (
      .clk156(clk156), .tx_axis_aresetn(aresetn), .tx_enable(tx_enable),
      .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep), .tx_axis_tvalid(tvalid),
      .tx_axis_tlast(tlast), .tx_axis_tready(tready),
      .xgmii_txd(txd), .xgmii_txc(txc), .tx_underrun(und)
`ifdef XGMII_TX_STATS_EN
      , .stat_frames(sf), .stat_underruns(su)
`endif
   );

   always #5 clk156 = ~clk156;

   always @(negedge clk156)
      if (cap_en) begin
         q_txd.push_back(txd);
         q_txc.push_back(txc);
         q_und.push_back(und);
      end

   function automatic logic [63:0] bdata(input int k);
      logic [7:0] b;
      b = 8'(k * 16);
      return 64'h0807060504030201 + {8{b}};
   endfunction

   function automatic int find(input logic [63:0] w, input logic [7:0] c, input int from);
      for (int i = from; i < q_txd.size(); i++)
         if (q_txd[i] === w && q_txc[i] === c) return i;
      return -1;
   endfunction

   function automatic int und_count();
      int n = 0;
      for (int i = 0; i < q_und.size(); i++) if (q_und[i] === 1'b1) n++;
      return n;
   endfunction

   task automatic cap_start();
      q_txd.delete(); q_txc.delete(); q_und.delete();
      cap_en = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk156); #1; end
   endtask

   // Drives nb beats honouring tready; drops tvalid for one cycle at beat 'hole' (-1: never).
   task automatic send(input int nb, input logic [7:0] lkeep, input int hole);
      int k; int cyc; bit holed; bit acc;
      k = 0; cyc = 0; holed = 1'b0;
      while (k < nb && cyc < 200) begin
         tdata = bdata(k); tkeep = (k == nb - 1) ? lkeep : 8'hFF;
         tlast = (k == nb - 1); tvalid = 1'b1;
         @(negedge clk156);
         if (tready && k == hole && !holed) begin tvalid = 1'b0; holed = 1'b1; end
         acc = tready && tvalid;
         @(posedge clk156); #1;
         if (acc) k++;
         cyc++;
      end
      tvalid = 1'b0; tlast = 1'b0; tkeep = 8'hFF;
      n_chk++;
      if (k != nb) begin n_fail++; $display("FAIL send_drain: accepted %0d beats, want %0d", k, nb); end
   endtask

   task automatic test_reset();
      #1 aresetn = 1'b0;
      #1;
      n_chk++;
      if (txd !== IDLE_W || txc !== 8'hFF || tready !== 1'b0 || und !== 1'b0) begin
         n_fail++; $display("FAIL reset_vals: txd=%h txc=%h rdy=%b und=%b want %h/FF/0/0", txd, txc, tready, und, IDLE_W);
      end
      idle_cycles(3);
      n_chk++;
      if (txd !== IDLE_W || tready !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold: txd=%h rdy=%b want %h/0", txd, tready, IDLE_W);
      end
      tvalid = 1'b0;
      aresetn = 1'b1;
      idle_cycles(3);
      n_chk++;
      if (txd !== IDLE_W || txc !== 8'hFF || tready !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: txd=%h txc=%h rdy=%b want idle", txd, txc, tready);
      end
   endtask

   task automatic test_full_frame();
      int p;
      cap_start(); send(8, 8'hFF, -1); idle_cycles(6); cap_en = 1'b0;
      p = find(PRE_W, 8'h01, 0);
      n_chk++;
      if (p < 0) begin n_fail++; $display("FAIL full_pre: no preamble word seen, want FB..D5/01"); end
      else begin
         for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (q_txd[p+1+k] !== bdata(k) || q_txc[p+1+k] !== 8'h00) begin
               n_fail++; $display("FAIL full_data%0d: txd=%h txc=%h want %h/00", k, q_txd[p+1+k], q_txc[p+1+k], bdata(k));
            end
         end
         n_chk++;
         if (q_txd[p+9] !== TERM_W || q_txc[p+9] !== 8'hFF) begin
            n_fail++; $display("FAIL full_term: txd=%h txc=%h want %h/FF", q_txd[p+9], q_txc[p+9], TERM_W);
         end
         n_chk++;
         if (q_txd[p+10] !== IDLE_W || q_txd[p+11] !== IDLE_W || q_txc[p+10] !== 8'hFF) begin
            n_fail++; $display("FAIL full_ifg: txd=%h,%h want idle,idle", q_txd[p+10], q_txd[p+11]);
         end
      end
      n_chk++;
      if (und_count() != 0) begin n_fail++; $display("FAIL full_underrun: %0d pulses, want 0", und_count()); end
   endtask

   task automatic test_partial_last();
      int p; logic [63:0] d2;
      d2 = bdata(2);
      cap_start(); send(3, 8'h07, -1); idle_cycles(5); cap_en = 1'b0;
      p = find(PRE_W, 8'h01, 0);
      n_chk++;
      if (p < 0) begin n_fail++; $display("FAIL part_pre: no preamble word seen"); end
      else begin
         n_chk++;
         if (q_txd[p+3] !== {32'h07070707, 8'hFD, d2[23:0]} || q_txc[p+3] !== 8'hF8) begin
            n_fail++; $display("FAIL part_last: txd=%h txc=%h want %h/F8", q_txd[p+3], q_txc[p+3], {32'h07070707, 8'hFD, d2[23:0]});
         end
         n_chk++;
         if (q_txd[p+4] !== IDLE_W || q_txc[p+4] !== 8'hFF) begin
            n_fail++; $display("FAIL part_noterm: txd=%h txc=%h want idle", q_txd[p+4], q_txc[p+4]);
         end
      end
   endtask

   task automatic test_keep_edges();
      logic [7:0]  keeps [4] = '{8'hF3, 8'h00, 8'h7F, 8'hBF};
      logic [7:0]  ctls  [4] = '{8'hFC, 8'hFF, 8'h80, 8'hC0};
      logic [63:0] d1, exp_w;
      int p;
      d1 = bdata(1);
      for (int t = 0; t < 4; t++) begin
         case (t)
            0:       exp_w = {40'h0707070707, 8'hFD, d1[15:0]};
            1:       exp_w = TERM_W;
            2:       exp_w = {8'hFD, d1[55:0]};
            default: exp_w = {8'h07, 8'hFD, d1[47:0]};
         endcase
         cap_start(); send(2, keeps[t], -1); idle_cycles(5); cap_en = 1'b0;
         p = find(PRE_W, 8'h01, 0);
         n_chk++;
         if (p < 0 || q_txd[p+1] !== bdata(0) || q_txd[p+2] !== exp_w || q_txc[p+2] !== ctls[t] || q_txd[p+3] !== IDLE_W) begin
            n_fail++;
            $display("FAIL keep_%h: pre@%0d last txd=%h txc=%h want %h/%h", keeps[t], p, (p < 0) ? 64'h0 : q_txd[p+2], (p < 0) ? 8'h0 : q_txc[p+2], exp_w, ctls[t]);
         end
      end
   endtask

   task automatic test_underrun();
      int p;
      cap_start(); send(5, 8'hFF, 2); idle_cycles(5); cap_en = 1'b0;
      p = find(PRE_W, 8'h01, 0);
      n_chk++;
      if (p < 0) begin n_fail++; $display("FAIL ur_pre: no preamble word seen"); end
      else begin
         n_chk++;
         if (q_txd[p+1] !== bdata(0) || q_txd[p+2] !== bdata(1)) begin
            n_fail++; $display("FAIL ur_data: %h,%h want %h,%h", q_txd[p+1], q_txd[p+2], bdata(0), bdata(1));
         end
         n_chk++;
         if (q_txd[p+3] !== ERR_W || q_txc[p+3] !== 8'hFF || q_und[p+3] !== 1'b1) begin
            n_fail++; $display("FAIL ur_err: txd=%h txc=%h und=%b want %h/FF/1", q_txd[p+3], q_txc[p+3], q_und[p+3], ERR_W);
         end
         n_chk++;
         if (q_txd[p+4] !== TERM_W || q_txc[p+4] !== 8'hFF) begin
            n_fail++; $display("FAIL ur_term: txd=%h txc=%h want %h/FF", q_txd[p+4], q_txc[p+4], TERM_W);
         end
         n_chk++;
         if (find(IDLE_W, 8'hFF, p+5) != p+5 || find(TERM_W, 8'hFF, p+5) != -1 || find(PRE_W, 8'h01, p+1) != -1) begin
            n_fail++; $display("FAIL ur_drop: non-idle word after error terminate");
         end
      end
      n_chk++;
      if (und_count() != 1) begin n_fail++; $display("FAIL ur_pulse: %0d pulses, want 1", und_count()); end
   endtask

   task automatic test_back_to_back();
      int t, f;
      cap_start(); send(2, 8'hFF, -1); send(2, 8'hFF, -1); idle_cycles(6); cap_en = 1'b0;
      t = find(TERM_W, 8'hFF, 0);
      f = (t < 0) ? -1 : find(PRE_W, 8'h01, t);
      n_chk++;
      if (t < 0 || f < 0 || f - t - 1 != IFG + 1) begin
         n_fail++; $display("FAIL b2b_gap: term@%0d pre@%0d gap %0d want %0d", t, f, f - t - 1, IFG + 1);
      end else begin
         n_chk++;
         if (q_txd[t+1] !== IDLE_W || q_txd[t+2] !== IDLE_W) begin
            n_fail++; $display("FAIL b2b_idle: %h,%h want idle", q_txd[t+1], q_txd[t+2]);
         end
         n_chk++;
         if (q_txd[f+1] !== bdata(0) || q_txd[f+2] !== bdata(1) || q_txd[f+3] !== TERM_W) begin
            n_fail++; $display("FAIL b2b_second: %h,%h,%h want %h,%h,%h", q_txd[f+1], q_txd[f+2], q_txd[f+3], bdata(0), bdata(1), TERM_W);
         end
      end
   endtask

   task automatic test_enable_gate();
      int p;
      tx_enable = 1'b0; tdata = bdata(0); tlast = 1'b0; tvalid = 1'b1;
      cap_start(); idle_cycles(6); cap_en = 1'b0;
      n_chk++;
      if (find(PRE_W, 8'h01, 0) != -1 || tready !== 1'b0) begin
         n_fail++; $display("FAIL gate_idle: preamble issued or tready=%b with tx_enable=0", tready);
      end
      cap_start(); tx_enable = 1'b1; idle_cycles(1); tx_enable = 1'b0;
      send(2, 8'hFF, -1);
      tdata = bdata(0); tvalid = 1'b1; idle_cycles(6); tvalid = 1'b0; cap_en = 1'b0;
      p = find(PRE_W, 8'h01, 0);
      n_chk++;
      if (p < 0 || q_txd[p+1] !== bdata(0) || q_txd[p+2] !== bdata(1) || q_txd[p+3] !== TERM_W) begin
         n_fail++; $display("FAIL gate_midframe: pre@%0d frame did not complete after disable", p);
      end
      n_chk++;
      if (p >= 0 && find(PRE_W, 8'h01, p+1) != -1) begin
         n_fail++; $display("FAIL gate_restart: second preamble with tx_enable=0");
      end
      tx_enable = 1'b1;
   endtask

   task automatic test_reset_midframe();
      tx_enable = 1'b1; tdata = bdata(3); tkeep = 8'hFF; tlast = 1'b0; tvalid = 1'b1;
      idle_cycles(3);
      n_chk++;
      if (txd !== bdata(3) || txc !== 8'h00 || tready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre: txd=%h txc=%h rdy=%b want %h/00/1", txd, txc, tready, bdata(3));
      end
      #2 aresetn = 1'b0;
      #1;
      n_chk++;
      if (txd !== IDLE_W || txc !== 8'hFF || tready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_async: txd=%h txc=%h rdy=%b want idle/FF/0", txd, txc, tready);
      end
      tvalid = 1'b0;
      idle_cycles(2);
      aresetn = 1'b1;
      idle_cycles(3);
      n_chk++;
      if (txd !== IDLE_W || txc !== 8'hFF || tready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_after: txd=%h txc=%h rdy=%b want idle", txd, txc, tready);
      end
   endtask

   task automatic test_stats();
      int npre;
      cap_start();
      send(2, 8'hFF, -1);
      send(4, 8'hFF, 1);
      send(3, 8'h0F, -1);
      send(2, 8'hFF, -1);
      idle_cycles(6); cap_en = 1'b0;
      npre = 0;
      for (int i = 0; i < q_txd.size(); i++) if (q_txd[i] === PRE_W && q_txc[i] === 8'h01) npre++;
      n_chk++;
      if (npre != 4 || und_count() != 1) begin
         n_fail++; $display("FAIL stats_traffic: %0d preambles %0d underruns, want 4/1", npre, und_count());
      end
`ifdef XGMII_TX_STATS_EN
      n_chk++;
      if (sf !== 32'd3) begin n_fail++; $display("FAIL stat_frames: got %0d want 3", sf); end
      n_chk++;
      if (su !== 16'd1) begin n_fail++; $display("FAIL stat_underruns: got %0d want 1", su); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_full_frame();
      test_partial_last();
      test_keep_edges();
      test_underrun();
      test_back_to_back();
      test_enable_gate();
      test_reset_midframe();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
